serial_nibble_adder_ctrl: RTL
=============================

// Module: serial_nibble_adder_ctrl
// PURPOSE
//   Sequences one instance of the team's 4-bit ripple-carry adder slice (ports a, b, c_in, s, c_out)
//   to add or subtract two WIDTH-bit operands, one nibble per clock, LSB nibble first.
//   Carry is held in a register between nibbles. Start/busy/done handshake; registered results.
//   Sits between the switch/LED test wrapper (or a host FSM) and the adder slice.
// PARAMETERS
//   WIDTH    16   operand/result width in bits; multiple of 4, >= 4 (NIB = WIDTH/4 is a derived localparam)
// PORTS
//   clock     in   1      single system clock, all state on rising edge
//   reset     in   1      synchronous, active-high
//   start     in   1      request a new operation; sampled only in IDLE
//   sub       in   1      0 = a+b, 1 = a-b; latched with operands
//   a         in   WIDTH  operand A; latched on accepted start
//   b         in   WIDTH  operand B; latched on accepted start
//   busy      out  1      high while nibbles are being processed (RUN)
//   done      out  1      one-cycle pulse: sum/c_out/overflow just updated
//   sum       out  WIDTH  result (two's complement for sub)
//   c_out     out  1      carry out of MSB; for sub, 1 = no borrow (a >= b unsigned)
//   overflow  out  1      signed overflow of the operation
// BEHAVIOUR
//   Reset: state=IDLE; busy=0, done=0, sum=0, c_out=0, overflow=0; carry, index, work regs cleared.
//   Reset mid-operation aborts it; no done pulse follows; outputs return to reset values next cycle.
//   FSM states: IDLE, RUN, DONE.
//   - IDLE: start=1 at edge k -> latch opA=a, opB=(sub ? ~b : b), carry=sub, idx=0; go RUN.
//     start=0 -> stay IDLE.
//   - RUN: slice inputs: opA[4*idx+:4], opB[4*idx+:4], c_in=carry.
//     Each edge: work[4*idx+:4] <= slice s; carry <= slice c_out; idx <= idx+1.
//     At idx==NIB-1: also sum <= final work, c_out <= slice c_out,
//     overflow <= slice c_out ^ (opA[WIDTH-1] ^ opB[WIDTH-1] ^ slice s[3]); go DONE.
//   - DONE: done=1 for exactly one cycle -> IDLE unconditionally.
//   Timing: start accepted at edge k -> busy=1 cycles k+1..k+NIB -> done=1 in cycle k+NIB+1.
//     Latency start->done = NIB+1 cycles. Earliest next accept: edge ending the DONE cycle + 1
//     (i.e. first IDLE cycle); throughput one op per NIB+2 cycles.
//   start while RUN or DONE: ignored, no queuing. a/b/sub changes after acceptance have no effect.
//   sum, c_out, overflow change only on the RUN->DONE edge (or reset); otherwise held, never partial.
//   Arithmetic: modulo 2^WIDTH; no saturation. WIDTH=4 (NIB=1) is legal: RUN lasts one cycle.
//   busy and done are never high in the same cycle.
// TESTING
//   1 WIDTH=16, a=0x1234, b=0x4321, sub=0, start pulse at edge k
//     -> busy k+1..k+4, done in k+5; sum=0x5555, c_out=0, overflow=0.
//   2 a=0xFFFF, b=0x0001, add -> sum=0x0000, c_out=1, overflow=0 (carry crosses all 4 nibbles);
//     a=0x7FFF, b=0x0001 -> sum=0x8000, c_out=0, overflow=1.
//   3 sub: a=0x0003, b=0x0005 -> sum=0xFFFE, c_out=0, overflow=0;
//     a=0x8000, b=0x0001 -> sum=0x7FFF, c_out=1, overflow=1.
//   4 start re-pulsed with a=0x1111 during RUN and in DONE -> ignored, first result returned;
//     start held high throughout -> ops accepted every 6 cycles, results in order.
//   5 reset asserted in 2nd RUN cycle -> next cycle busy=0, done=0, sum=0, c_out=0, overflow=0;
//     no done pulse follows.
//   6 WIDTH=4: a=4'h9, b=4'h8, add -> done 2 cycles after start; sum=4'h1, c_out=1, overflow=1.

Source files
------------

// File: rtl/serial_nibble_adder_ctrl_if.sv
// Handshake and operand/result bundle between a host (or switch/LED wrapper)
// and the serial nibble adder controller.
interface serial_nibble_adder_ctrl_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, c_out, overflow
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, c_out, overflow
    );
endinterface

// File: rtl/serial_nibble_adder_ctrl.sv
// Adds or subtracts two WIDTH-bit operands one nibble per clock through a single
// 4-bit ripple-carry slice, LSB nibble first, with a start/busy/done handshake.
module serial_nibble_adder_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    serial_nibble_adder_ctrl_if.slave  bus
);
    localparam int unsigned NIB   = WIDTH / 4;
    localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int unsigned SH_W  = IDX_W + 2;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

    generate
        if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_bad_width
            $error("serial_nibble_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic [WIDTH-1:0] work_q;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q;
    logic [WIDTH-1:0] sum_q;
    logic             c_out_q;
    logic             overflow_q;
    logic             busy_q;
    logic             done_q;

    logic             busy_d;
    logic             done_d;
    logic             last_nib;
    logic [SH_W-1:0]  nib_sh;
    logic [3:0]       sl_a;
    logic [3:0]       sl_b;
    logic [3:0]       sl_s;
    logic             sl_c;
    logic             rc;
    logic [WIDTH-1:0] work_nxt;

    assign last_nib = (idx_q == IDX_LAST);
    assign nib_sh   = {idx_q, 2'b00};

    // 4-bit ripple-carry slice fed with the current operand nibbles and held carry
    always_comb begin
        sl_a = 4'(op_a_q >> nib_sh);
        sl_b = 4'(op_b_q >> nib_sh);
        sl_s = 4'h0;
        rc   = carry_q;
        for (int i = 0; i < 4; i++) begin
            sl_s[i] = sl_a[i] ^ sl_b[i] ^ rc;
            rc      = (sl_a[i] & sl_b[i]) | (rc & (sl_a[i] ^ sl_b[i]));
        end
        sl_c = rc;
    end

    // Merge the fresh slice nibble into the partial result
    assign work_nxt = (work_q & ~(WIDTH'(4'hF) << nib_sh)) | (WIDTH'(sl_s) << nib_sh);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_RUN;
            S_RUN:   if (last_nib)  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so they line up with it
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            S_RUN:   busy_d = 1'b1;
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            op_a_q     <= '0;
            op_b_q     <= '0;
            work_q     <= '0;
            idx_q      <= '0;
            carry_q    <= 1'b0;
            sum_q      <= '0;
            c_out_q    <= 1'b0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        // Subtraction is a + ~b + 1, the +1 entering as the initial carry
                        op_a_q  <= bus.a;
                        op_b_q  <= bus.sub ? ~bus.b : bus.b;
                        carry_q <= bus.sub;
                        idx_q   <= '0;
                        work_q  <= '0;
                    end
                end
                S_RUN: begin
                    work_q  <= work_nxt;
                    carry_q <= sl_c;
                    idx_q   <= idx_q + IDX_W'(1);
                    if (last_nib) begin
                        sum_q      <= work_nxt;
                        c_out_q    <= sl_c;
                        overflow_q <= sl_c ^ (op_a_q[WIDTH-1] ^ op_b_q[WIDTH-1] ^ sl_s[3]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.sum      = sum_q;
    assign bus.c_out    = c_out_q;
    assign bus.overflow = overflow_q;
endmodule
